// File: rtl/thor2024_fetchbuf.sv
// Instruction fetch buffer: filters I-cache responses by PC, queues up to DEPTH
// instructions and presents the two oldest to the enqueue stage.
module thor2024_fetchbuf #(
  parameter int               DEPTH       = 4,
  parameter int               IW          = 40,
  parameter int               PCW         = 32,
  parameter int               INSTR_BYTES = 5,
  parameter logic [PCW-1:0]   RSTPC       = 32'hFFFD0000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ic_v,
  input  logic           ic_v1,
  input  logic [PCW-1:0] ic_pc,
  input  logic [IW-1:0]  ic_instr0,
  input  logic [IW-1:0]  ic_instr1,
  output logic           ic_rdy,
  output logic [PCW-1:0] fetch_pc,
  input  logic           branchmiss,
  input  logic [PCW-1:0] misspc,
  input  logic           take0,
  input  logic           take1,
  output logic           fetchbuf0_v,
  output logic [IW-1:0]  fetchbuf0_instr,
  output logic [PCW-1:0] fetchbuf0_pc,
  output logic           fetchbuf1_v,
  output logic [IW-1:0]  fetchbuf1_instr,
  output logic [PCW-1:0] fetchbuf1_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PCW-1:0] STEP1 = PCW'(INSTR_BYTES);
  localparam logic [PCW-1:0] STEP2 = PCW'(2 * INSTR_BYTES);

  typedef struct packed {
    logic [IW-1:0]  instr;
    logic [PCW-1:0] pc;
  } entry_t;

  entry_t         r_storage [DEPTH];
  logic [PW-1:0]  r_rdptr;
  logic [PW-1:0]  r_wrptr;
  logic [CW-1:0]  r_count;
  logic [PCW-1:0] r_fetch_pc;

  logic           w_ic_rdy;
  logic           w_fb0_v;
  logic           w_fb1_v;
  logic           w_accept;
  logic [1:0]     w_npush;
  logic [1:0]     w_npop;
  logic [PCW-1:0] w_pc_inc;
  logic [PW-1:0]  w_rd1;
  logic [PW-1:0]  w_wr1;

  assign w_rd1    = r_rdptr + PW'(1);
  assign w_wr1    = r_wrptr + PW'(1);
  assign w_ic_rdy = (r_count <= CW'(DEPTH - 2));
  assign w_fb0_v  = (r_count >= CW'(1));
  assign w_fb1_v  = (r_count >= CW'(2));

  // Stale responses (wrong PC) and anything arriving with a redirect are dropped.
  assign w_accept = ic_v & w_ic_rdy & (ic_pc == r_fetch_pc) & ~branchmiss;

  always_comb begin
    w_npush  = 2'd0;
    w_npop   = 2'd0;
    w_pc_inc = '0;
    if (w_accept) begin
      w_npush  = ic_v1 ? 2'd2 : 2'd1;
      w_pc_inc = ic_v1 ? STEP2 : STEP1;
    end
    if (take0 && w_fb0_v)
      w_npop = (take1 && w_fb1_v) ? 2'd2 : 2'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdptr    <= '0;
      r_wrptr    <= '0;
      r_count    <= '0;
      r_fetch_pc <= RSTPC;
    end else if (branchmiss) begin
      r_rdptr    <= '0;
      r_wrptr    <= '0;
      r_count    <= '0;
      r_fetch_pc <= misspc;
    end else begin
      r_rdptr    <= r_rdptr + PW'(w_npop);
      r_wrptr    <= r_wrptr + PW'(w_npush);
      r_count    <= r_count + CW'(w_npush) - CW'(w_npop);
      r_fetch_pc <= r_fetch_pc + w_pc_inc;
    end
  end

  // NOTE: the storage array has no reset; validity is tracked solely by
  // r_count, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_storage[r_wrptr] <= '{instr: ic_instr0, pc: ic_pc};
      if (ic_v1)
        r_storage[w_wr1] <= '{instr: ic_instr1, pc: ic_pc + STEP1};
    end
  end

  assign ic_rdy          = w_ic_rdy;
  assign fetch_pc        = r_fetch_pc;
  assign fetchbuf0_v     = w_fb0_v;
  assign fetchbuf0_instr = r_storage[r_rdptr].instr;
  assign fetchbuf0_pc    = r_storage[r_rdptr].pc;
  assign fetchbuf1_v     = w_fb1_v;
  assign fetchbuf1_instr = r_storage[w_rd1].instr;
  assign fetchbuf1_pc    = r_storage[w_rd1].pc;

endmodule

// File: tb/tb_thor2024_fetchbuf.sv
// Directed, table-driven bench for thor2024_fetchbuf: each vector is one clock
// of stimulus followed by the expected post-edge outputs.
module tb_thor2024_fetchbuf;

  localparam logic [31:0] B = 32'hFFFD0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_v, ic_v1;
  logic [31:0] ic_pc;
  logic [39:0] ic_instr0, ic_instr1;
  logic        ic_rdy;
  logic [31:0] fetch_pc;
  logic        branchmiss;
  logic [31:0] misspc;
  logic        take0, take1;
  logic        fetchbuf0_v, fetchbuf1_v;
  logic [39:0] fetchbuf0_instr, fetchbuf1_instr;
  logic [31:0] fetchbuf0_pc, fetchbuf1_pc;

  int n_checks = 0;
  int n_fail   = 0;

  thor2024_fetchbuf dut (
    .clk(clk), .rst(rst),
    .ic_v(ic_v), .ic_v1(ic_v1), .ic_pc(ic_pc),
    .ic_instr0(ic_instr0), .ic_instr1(ic_instr1),
    .ic_rdy(ic_rdy), .fetch_pc(fetch_pc),
    .branchmiss(branchmiss), .misspc(misspc),
    .take0(take0), .take1(take1),
    .fetchbuf0_v(fetchbuf0_v), .fetchbuf0_instr(fetchbuf0_instr), .fetchbuf0_pc(fetchbuf0_pc),
    .fetchbuf1_v(fetchbuf1_v), .fetchbuf1_instr(fetchbuf1_instr), .fetchbuf1_pc(fetchbuf1_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v, v1;
    logic [31:0] pc;
    logic        bm;
    logic [31:0] mpc;
    logic        t0, t1;
    logic        e_rdy;
    logic [31:0] e_fpc;
    logic        e_v0, e_v1;
    logic [31:0] e_pc0, e_pc1;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instructions carry a tag plus their own PC so data can be checked from the expected PC.
  function automatic logic [39:0] tag(input logic [31:0] pc);
    return {8'hAA, pc};
  endfunction

  task automatic drive(input logic v, input logic v1, input logic [31:0] pc,
                       input logic bm, input logic [31:0] mpc,
                       input logic t0, input logic t1);
    ic_v = v; ic_v1 = v1; ic_pc = pc;
    ic_instr0 = tag(pc); ic_instr1 = tag(pc + 32'd5);
    branchmiss = bm; misspc = mpc; take0 = t0; take1 = t1;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string n, input logic e_rdy, input logic [31:0] e_fpc,
                            input logic e_v0, input logic e_v1,
                            input logic [31:0] e_pc0, input logic [31:0] e_pc1);
    check({n, " ic_rdy"},   64'(ic_rdy),      64'(e_rdy));
    check({n, " fetch_pc"}, 64'(fetch_pc),    64'(e_fpc));
    check({n, " fb0_v"},    64'(fetchbuf0_v), 64'(e_v0));
    check({n, " fb1_v"},    64'(fetchbuf1_v), 64'(e_v1));
    if (e_v0) begin
      check({n, " fb0_pc"},    64'(fetchbuf0_pc),    64'(e_pc0));
      check({n, " fb0_instr"}, 64'(fetchbuf0_instr), 64'(tag(e_pc0)));
    end
    if (e_v1) begin
      check({n, " fb1_pc"},    64'(fetchbuf1_pc),    64'(e_pc1));
      check({n, " fb1_instr"}, 64'(fetchbuf1_instr), 64'(tag(e_pc1)));
    end
  endtask

  initial begin
    //            v     v1    pc             bm    mpc            t0    t1    rdy   fpc            v0    v1    pc0            pc1
    vecs[0]  = '{1'b1, 1'b1, B,             1'b0, 32'h0,         1'b0, 1'b0, 1'b1, B+32'h0A,      1'b1, 1'b1, B,             B+32'h05};
    vecs[1]  = '{1'b1, 1'b1, B+32'h0A,      1'b0, 32'h0,         1'b0, 1'b0, 1'b0, B+32'h14,      1'b1, 1'b1, B,             B+32'h05};
    vecs[2]  = '{1'b1, 1'b1, B+32'h14,      1'b0, 32'h0,         1'b0, 1'b0, 1'b0, B+32'h14,      1'b1, 1'b1, B,             B+32'h05};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 1'b1, B+32'h14,      1'b1, 1'b1, B+32'h0A,      B+32'h0F};
    vecs[4]  = '{1'b1, 1'b1, B+32'h14,      1'b0, 32'h0,         1'b1, 1'b1, 1'b1, B+32'h1E,      1'b1, 1'b1, B+32'h14,      B+32'h19};
    vecs[5]  = '{1'b1, 1'b1, B+32'h0A,      1'b0, 32'h0,         1'b0, 1'b0, 1'b1, B+32'h1E,      1'b1, 1'b1, B+32'h14,      B+32'h19};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b1, B+32'h1E,      1'b1, 1'b1, B+32'h14,      B+32'h19};
    vecs[7]  = '{1'b1, 1'b1, B+32'h1E,      1'b1, 32'h00001000,  1'b1, 1'b0, 1'b1, 32'h00001000,  1'b0, 1'b0, 32'h0,         32'h0};
    vecs[8]  = '{1'b1, 1'b0, 32'h00001000,  1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h00001005,  1'b1, 1'b0, 32'h00001000,  32'h0};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h00001005,  1'b0, 1'b0, 32'h0,         32'h0};
    vecs[10] = '{1'b1, 1'b0, 32'h00001005,  1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0000100A,  1'b1, 1'b0, 32'h00001005,  32'h0};
    vecs[11] = '{1'b1, 1'b0, 32'h0000100A,  1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0000100F,  1'b1, 1'b0, 32'h0000100A,  32'h0};
    vecs[12] = '{1'b1, 1'b1, 32'h0000100F,  1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h00001019,  1'b1, 1'b1, 32'h0000100F,  32'h00001014};
    vecs[13] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h00001019,  1'b0, 1'b0, 32'h0,         32'h0};
    vecs[14] = '{1'b1, 1'b1, 32'h00001019,  1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h00001023,  1'b1, 1'b1, 32'h00001019,  32'h0000101E};
    vecs[15] = '{1'b1, 1'b0, 32'h00001023,  1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h00001028,  1'b1, 1'b1, 32'h00001019,  32'h0000101E};
    vecs[16] = '{1'b1, 1'b1, 32'h00001028,  1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h00001028,  1'b1, 1'b1, 32'h00001019,  32'h0000101E};
    vecs[17] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h00001028,  1'b1, 1'b1, 32'h0000101E,  32'h00001023};

    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check_outs("reset", 1'b1, B, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].v, vecs[i].v1, vecs[i].pc, vecs[i].bm, vecs[i].mpc, vecs[i].t0, vecs[i].t1);
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_fpc,
                 vecs[i].e_v0, vecs[i].e_v1, vecs[i].e_pc0, vecs[i].e_pc1);
    end

    // Asynchronous reset mid-operation: state clears without a clock edge.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_outs("async_rst", 1'b1, B, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    rst = 1'b0;

    // Fetch PC wraps modulo 2^32 across a pair push.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    step();
    check_outs("redir_hi", 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    check_outs("pc_wrap", 1'b1, 32'h00000008, 1'b1, 1'b1, 32'hFFFFFFFE, 32'h00000003);

    // A response with ic_v=0 never pushes even when ic_pc matches.
    drive(1'b0, 1'b1, 32'h00000008, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    check_outs("no_valid", 1'b1, 32'h00000008, 1'b1, 1'b1, 32'hFFFFFFFE, 32'h00000003);

    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
